hdmi_audio_sample_packer: RTL and testbench

Sits in the HDMI pixel-clock domain, downstream of the audio samplerate restrober. It buffers strobed 16-bit stereo samples in a small FIFO. On request from the data-island scheduler, it assembles one HDMI Audio Sample Packet (layout 0, 2ch, up to 4 samples) with IEC60958 V/U/C/P bits and block-start flags. The packet is handed to the TERC4 encoder via a valid/ready handshake.

---
 rtl/hdmi_audio_pkg.sv | 51 +++++
 rtl/audio_sample_fifo.sv | 52 +++++
 rtl/hdmi_audio_sample_packer.sv | 127 ++++++++++++
 tb/tb_hdmi_audio_sample_packer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_audio_pkg.sv
// Shared constants, types and helpers for the HDMI audio sample packer.
// Optional build macro HDMI_AUDIO_CHSTAT_EN (used by the top) selects
// channel-status driven C bits.
package hdmi_audio_pkg;

  localparam logic [7:0]  HB0       = 8'h02;
  localparam int unsigned FRAME_LEN = 192;

  // fs codes as stored in channel-status bits 24..27 (bit 24 = code[0]).
  localparam logic [3:0] FS_CODE_44K1 = 4'b0000;
  localparam logic [3:0] FS_CODE_48K  = 4'b0010;
  localparam logic [3:0] FS_CODE_32K  = 4'b0011;
  localparam logic [3:0] FS_CODE_96K  = 4'b1010;
  localparam logic [3:0] FS_CODE_192K = 4'b1110;
  localparam logic [3:0] FS_CODE_NONE = 4'b0001;

  typedef enum logic [1:0] {IDLE, LOAD, VALID} state_e;

  function automatic logic [3:0] fs_code(input int unsigned rate);
    case (rate)
      32000:   return FS_CODE_32K;
      44100:   return FS_CODE_44K1;
      48000:   return FS_CODE_48K;
      96000:   return FS_CODE_96K;
      192000:  return FS_CODE_192K;
      default: return FS_CODE_NONE;
    endcase
  endfunction

  // Consumer channel-status block: copy permitted, fs code, 16-bit word length.
  function automatic logic chstat_bit(input logic [7:0] idx, input logic [3:0] code);
    logic [191:0] v;
    v          = '0;
    v[2]       = 1'b1;
    v[27:24]   = code;
    v[35:32]   = 4'b0010;
    return v[idx];
  endfunction

  // One 2ch subpacket: 24-bit L, 24-bit R, then {PR,CR,UR,VR,PL,CL,UL,VL}.
  // V and U are always 0, so parity covers the sample bits and C only.
  function automatic logic [55:0] pack_subpacket(input logic [15:0] l, input logic [15:0] r,
                                                 input logic cl, input logic cr);
    logic pl;
    logic pr;
    pl = ^{l, cl};
    pr = ^{r, cr};
    return {pr, cr, 1'b0, 1'b0, pl, cl, 1'b0, 1'b0, r, 8'h00, l, 8'h00};
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// DEPTH x 32 show-ahead FIFO with level output. A push while full is accepted
// only when a pop happens in the same cycle.
module audio_sample_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [31:0]              wdata,
  input  logic                     pop,
  output logic [31:0]              rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   level_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rptr_q];
  assign level   = level_q;

  // Pointer and level bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (do_pop && !do_push) level_q <= level_q - 1'b1;
    end
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/hdmi_audio_sample_packer.sv
// Buffers stereo samples and assembles HDMI Audio Sample Packets (layout 0,
// up to 4 samples) on scheduler request. Build macro HDMI_AUDIO_CHSTAT_EN
// drives C bits from the IEC60958 channel-status block; otherwise C=0.
module hdmi_audio_sample_packer
  import hdmi_audio_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned SAMPLERATE = 192000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [15:0]              in_l,
  input  logic [15:0]              in_r,
  input  logic                     in_stb,
  input  logic                     pkt_req,
  input  logic                     pkt_ready,
  output logic                     pkt_valid,
  output logic [23:0]              pkt_hdr,
  output logic [223:0]             pkt_sub,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  // Reject configurations the FIFO pointers and fs table cannot support.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || SAMPLERATE == 0) begin : g_bad_cfg
    $error("hdmi_audio_sample_packer: unsupported DEPTH/SAMPLERATE");
  end

  logic [31:0]  fifo_rdata;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_pop;
  state_e       state_q;
  logic [2:0]   n_q;
  logic [1:0]   idx_q;
  logic [7:0]   frame_q;
  logic [23:0]  hdr_q;
  logic [223:0] sub_q;
  logic         valid_q;
  logic         overflow_q;
  logic         c_bit;

  assign fifo_pop = (state_q == LOAD);

  audio_sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (in_stb),
    .wdata   ({in_l, in_r}),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef HDMI_AUDIO_CHSTAT_EN
  localparam logic [3:0] FS_CODE = fs_code(SAMPLERATE);
  assign c_bit = chstat_bit(frame_q, FS_CODE);
`else
  assign c_bit = 1'b0;
`endif

  assign pkt_valid = valid_q;
  assign pkt_hdr   = hdr_q;
  assign pkt_sub   = sub_q;
  assign overflow  = overflow_q;

  // Sticky drop flag: a strobe at full with no pop to make room.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (in_stb && fifo_full && !fifo_pop) begin
      overflow_q <= 1'b1;
    end
  end

  // Packet FSM: latch count, pop into slots, then hold until accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      hdr_q   <= '0;
      sub_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pkt_req && !fifo_empty) begin
            n_q     <= (fifo_level > LW'(3)) ? 3'd4 : 3'(fifo_level);
            idx_q   <= '0;
            sub_q   <= '0;
            hdr_q   <= {16'h0000, HB0};
            state_q <= LOAD;
          end
        end
        LOAD: begin
          sub_q[56 * int'(idx_q) +: 56] <= pack_subpacket(fifo_rdata[31:16], fifo_rdata[15:0],
                                                          c_bit, c_bit);
          hdr_q[8 + int'(idx_q)] <= 1'b1;
          // Block start flag for the sample that opens a 192-frame block.
          if (frame_q == 8'd0) hdr_q[20 + int'(idx_q)] <= 1'b1;
          frame_q <= (frame_q == 8'(FRAME_LEN - 1)) ? 8'd0 : frame_q + 8'd1;
          idx_q   <= idx_q + 2'd1;
          if ({1'b0, idx_q} == n_q - 3'd1) begin
            state_q <= VALID;
            valid_q <= 1'b1;
          end
        end
        VALID: begin
          if (pkt_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_audio_sample_packer.sv
// Scoreboard bench for hdmi_audio_sample_packer: a queue-based reference model
// predicts packets, FIFO level and overflow; a negedge monitor compares.
module tb_hdmi_audio_sample_packer;

  localparam int unsigned DEPTH = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [15:0]  in_l = '0;
  logic [15:0]  in_r = '0;
  logic         in_stb = 1'b0;
  logic         pkt_req = 1'b0;
  logic         pkt_ready = 1'b0;
  logic         pkt_valid;
  logic [23:0]  pkt_hdr;
  logic [223:0] pkt_sub;
  logic [3:0]   fifo_level;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hdmi_audio_sample_packer #(
    .DEPTH      (DEPTH),
    .SAMPLERATE (192000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_l       (in_l),
    .in_r       (in_r),
    .in_stb     (in_stb),
    .pkt_req    (pkt_req),
    .pkt_ready  (pkt_ready),
    .pkt_valid  (pkt_valid),
    .pkt_hdr    (pkt_hdr),
    .pkt_sub    (pkt_sub),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]  mq[$];
  logic [23:0]  exp_hdr[$];
  logic [223:0] exp_sub[$];
  int           pops_left = 0;
  int           n_m = 0;
  int           frame_m = 0;
  bit           waiting = 0;
  bit           ovf_m = 0;
  logic [223:0] cur_sub;
  logic [3:0]   cur_present;
  logic [3:0]   cur_b;

  function automatic int ref_cbit(input int idx);
`ifdef HDMI_AUDIO_CHSTAT_EN
    return (idx == 2 || idx == 25 || idx == 26 || idx == 27 || idx == 33) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic logic [55:0] ref_slot(input logic [15:0] l, input logic [15:0] r,
                                           input int cidx);
    logic [7:0]  b [7];
    logic [55:0] s;
    int c, pl, pr;
    c  = ref_cbit(cidx);
    pl = ($countones(l) + c) % 2;
    pr = ($countones(r) + c) % 2;
    b[0] = 8'h00; b[1] = l[7:0]; b[2] = l[15:8];
    b[3] = 8'h00; b[4] = r[7:0]; b[5] = r[15:8];
    b[6] = 8'(pr * 128 + c * 64 + pl * 8 + c * 4);
    for (int k = 0; k < 7; k++) s[8*k +: 8] = b[k];
    return s;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int sz0;
    bit idle0;
    logic [31:0] smp;
    int slot;
    if (!reset_n) begin
      mq.delete(); exp_hdr.delete(); exp_sub.delete();
      pops_left = 0; n_m = 0; frame_m = 0; waiting = 0; ovf_m = 0;
    end else begin
      sz0   = mq.size();
      idle0 = (pops_left == 0) && !waiting;
      if (waiting && pkt_ready) waiting = 0;
      if (pops_left > 0) begin
        slot = n_m - pops_left;
        smp  = mq.pop_front();
        cur_sub[56*slot +: 56] = ref_slot(smp[31:16], smp[15:0], frame_m);
        cur_present[slot] = 1'b1;
        if (frame_m == 0) cur_b[slot] = 1'b1;
        frame_m = (frame_m + 1) % 192;
        pops_left--;
        if (pops_left == 0) begin
          exp_hdr.push_back({cur_b, 4'h0, 4'h0, cur_present, 8'h02});
          exp_sub.push_back(cur_sub);
          waiting = 1;
        end
      end
      if (idle0 && pkt_req && sz0 > 0) begin
        n_m = (sz0 > 4) ? 4 : sz0;
        pops_left = n_m;
        cur_sub = '0; cur_present = '0; cur_b = '0;
      end
      if (in_stb) begin
        if (mq.size() < DEPTH) mq.push_back({in_l, in_r});
        else ovf_m = 1;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      check("pkt_valid", 256'(pkt_valid), 256'(waiting));
      check("fifo_level", 256'(fifo_level), 256'(mq.size()));
      check("overflow", 256'(overflow), 256'(ovf_m));
      if (pkt_valid) begin
        if (exp_hdr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_packet actual=%0h expected=none", pkt_hdr);
        end else begin
          check("pkt_hdr", 256'(pkt_hdr), 256'(exp_hdr[0]));
          check("pkt_sub", 256'(pkt_sub), 256'(exp_sub[0]));
          if (pkt_ready) begin
            void'(exp_hdr.pop_front());
            void'(exp_sub.pop_front());
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    in_l = l; in_r = r; in_stb = 1'b1;
    step();
    in_stb = 1'b0;
  endtask

  task automatic request();
    pkt_req = 1'b1;
    step();
    pkt_req = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!pkt_valid && k < budget) begin
      step();
      k++;
    end
    if (!pkt_valid) begin
      checks++; errors++;
      $display("FAIL wait_valid timeout actual=0 expected=1");
    end
  endtask

  task automatic accept();
    wait_valid(20);
    pkt_ready = 1'b1;
    step();
    pkt_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 256'(pkt_valid), 256'(0));
    check({tag, "_hdr"}, 256'(pkt_hdr), 256'(0));
    check({tag, "_sub"}, 256'(pkt_sub), 256'(0));
    check({tag, "_level"}, 256'(fifo_level), 256'(0));
    check({tag, "_ovf"}, 256'(overflow), 256'(0));
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic drain();
    pkt_req = 1'b0; in_stb = 1'b0; pkt_ready = 1'b0;
    step();
    if (pkt_valid || pops_left > 0) accept();
    for (int k = 0; k < 50 && mq.size() > 0; k++) begin
      request();
      accept();
    end
  endtask

  initial begin
    int b_ones;
    int lvl;
    // Reset state
    step(); step();
    check_all_zero("in_reset");
    reset_n = 1'b1;
    step();
    check_all_zero("post_reset");

    // Request with empty FIFO is ignored
    pkt_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check("empty_req_valid", 256'(pkt_valid), 256'(0));
    end
    pkt_req = 1'b0;

    // Three-sample packet and latency
    push(16'h1234, 16'hABCD);
    push(16'h8000, 16'h0001);
    push(16'hFFFF, 16'h0000);
    request();
    step(); step();
    check("lat_before", 256'(pkt_valid), 256'(0));
    step();
    check("lat_at", 256'(pkt_valid), 256'(1));
    check("hb1_3", 256'(pkt_hdr[15:8]), 256'(8'h07));
    check("hb2_b", 256'(pkt_hdr[23:20]), 256'(4'b0001));
    check("sub0_bytes", 256'(pkt_sub[47:0]), 256'(48'hABCD00123400));
    check("sub3_zero", 256'(pkt_sub[223:168]), 256'(0));
    accept();

    // Six samples: full packet then remainder
    for (int k = 0; k < 6; k++) push(16'(k * 16'h1111 + 1), 16'(16'hF00F - k));
    request();
    wait_valid(20);
    check("hb1_4", 256'(pkt_hdr[15:8]), 256'(8'h0F));
    check("level_after_pops", 256'(fifo_level), 256'(2));
    accept();
    request();
    wait_valid(20);
    check("hb1_2", 256'(pkt_hdr[15:8]), 256'(8'h03));
    accept();

    // 200-sample stream from a fresh frame counter
    do_reset();
    b_ones = 0;
    for (int p = 0; p < 50; p++) begin
      for (int k = 0; k < 4; k++) push(16'($urandom), 16'($urandom));
      request();
      wait_valid(20);
      b_ones += $countones(pkt_hdr[23:20]);
      if (p == 0 || p == 48) check("b_slot0", 256'(pkt_hdr[20]), 256'(1));
      accept();
    end
    check("b_total", 256'(b_ones), 256'(2));

    // Backpressure: outputs held while samples keep arriving
    push(16'h0102, 16'h0304);
    push(16'h0506, 16'h0708);
    request();
    wait_valid(20);
    lvl = int'(fifo_level);
    for (int k = 0; k < 10; k++) begin
      in_stb = (k == 2 || k == 6);
      in_l = 16'(16'h5000 + k); in_r = 16'(16'h6000 + k);
      step();
    end
    in_stb = 1'b0;
    check("hold_level", 256'(fifo_level), 256'(lvl + 2));
    accept();
    drain();

    // Overflow and push-at-full with a same-cycle pop
    do_reset();
    for (int k = 0; k < 9; k++) push(16'(16'hA000 + k), 16'(16'hB000 + k));
    check("ovf_level", 256'(fifo_level), 256'(8));
    check("ovf_flag", 256'(overflow), 256'(1));
    request();
    push(16'hC0DE, 16'hBEEF);
    check("full_push_pop", 256'(fifo_level), 256'(8));
    accept();
    drain();

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      in_stb    = ($urandom % 3) == 0;
      in_l      = 16'($urandom);
      in_r      = 16'($urandom);
      pkt_req   = ($urandom % 4) == 0;
      pkt_ready = ($urandom % 2) == 0;
      step();
    end
    drain();

    // Reset during LOAD clears everything at once
    for (int k = 0; k < 4; k++) push(16'($urandom), 16'($urandom));
    request();
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("mid_load_reset");
    step();
    reset_n = 1'b1;
    step(); step();
    check_all_zero("after_mid_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
